// File: rtl/stage3_fast_sched_pkg.sv
// Shared definitions for the stage-3 FAST/NS sequencer: widths, length bounds,
// dictionary reset defaults, FSM encoding and slot-walking helpers.
package stage3_fast_sched_pkg;

  localparam int FAST_MESSAGE_BITS = 64;
  localparam int FAST_LENGTH_BITS  = 8;
  localparam int FIELD_PID1_BITS   = 8;
  localparam int FIELD_MC1_BITS    = 8;
  localparam int FIELD_MT1_BITS    = 8;

  localparam int NUM_SLOTS = 3;
  localparam int LEN_MIN   = 10;
  localparam int LEN_MAX   = 13;

  localparam int PID_RST_DEF = 0;
  localparam int MC_RST_DEF  = 0;
  localparam int MT_RST_DEF  = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Index of the lowest set mask bit at or above 'from' (0 if none).
  function automatic logic [1:0] next_set(input logic [2:0] mask, input logic [1:0] from);
    logic [1:0] r;
    r = 2'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (i >= int'(from) && mask[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic has_higher(input logic [2:0] mask, input logic [1:0] ptr);
    logic [2:0] above;
    above = mask >> ptr;
    return |above[2:1];
  endfunction

endpackage

// File: rtl/stage3_fast_dict_reg.sv
// PID1/MC1/MT1 dictionary registers. Two write sources: configuration load
// and the end-of-triple update; the update wins if both are ever raised.
module stage3_fast_dict_reg
  import stage3_fast_sched_pkg::*;
#(
  parameter int PID_W = FIELD_PID1_BITS,
  parameter int MC_W  = FIELD_MC1_BITS,
  parameter int MT_W  = FIELD_MT1_BITS,
  parameter logic [PID_W-1:0] PID_RST = PID_W'(PID_RST_DEF),
  parameter logic [MC_W-1:0]  MC_RST  = MC_W'(MC_RST_DEF),
  parameter logic [MT_W-1:0]  MT_RST  = MT_W'(MT_RST_DEF)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [PID_W-1:0] cfg_pid,
  input  logic [MC_W-1:0]  cfg_mc,
  input  logic [MT_W-1:0]  cfg_mt,
  input  logic             upd_we,
  input  logic [PID_W-1:0] upd_pid,
  input  logic [MC_W-1:0]  upd_mc,
  input  logic [MT_W-1:0]  upd_mt,
  output logic [PID_W-1:0] field_pid,
  output logic [MC_W-1:0]  field_mc,
  output logic [MT_W-1:0]  field_mt
);

  logic [PID_W-1:0] pid_reg;
  logic [MC_W-1:0]  mc_reg;
  logic [MT_W-1:0]  mt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pid_reg <= PID_RST;
      mc_reg  <= MC_RST;
      mt_reg  <= MT_RST;
    end else if (upd_we) begin
      pid_reg <= upd_pid;
      mc_reg  <= upd_mc;
      mt_reg  <= upd_mt;
    end else if (cfg_we) begin
      pid_reg <= cfg_pid;
      mc_reg  <= cfg_mc;
      mt_reg  <= cfg_mt;
    end
  end

  assign field_pid = pid_reg;
  assign field_mc  = mc_reg;
  assign field_mt  = mt_reg;

endmodule

// File: rtl/stage3_fast_sched.sv
// Stage-3 FAST/NS sequencer: captures a triple of encoded messages and drains
// the populated slots one beat at a time, then updates the dictionary.
module stage3_fast_sched
  import stage3_fast_sched_pkg::*;
#(
  parameter int FAST_W = FAST_MESSAGE_BITS,
  parameter int LEN_W  = FAST_LENGTH_BITS,
  parameter int PID_W  = FIELD_PID1_BITS,
  parameter int MC_W   = FIELD_MC1_BITS,
  parameter int MT_W   = FIELD_MT1_BITS,
  parameter logic [PID_W-1:0] PID_RST = PID_W'(PID_RST_DEF),
  parameter logic [MC_W-1:0]  MC_RST  = MC_W'(MC_RST_DEF),
  parameter logic [MT_W-1:0]  MT_RST  = MT_W'(MT_RST_DEF)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mask,
  input  logic [FAST_W-1:0] msg_fast_1,
  input  logic [FAST_W-1:0] msg_fast_2,
  input  logic [FAST_W-1:0] msg_fast_3,
  input  logic [LEN_W-1:0]  len_1,
  input  logic [LEN_W-1:0]  len_2,
  input  logic [LEN_W-1:0]  len_3,
  input  logic [PID_W-1:0]  pid_1,
  input  logic [PID_W-1:0]  pid_2,
  input  logic [PID_W-1:0]  pid_3,
  input  logic [MC_W-1:0]   mc_1,
  input  logic [MC_W-1:0]   mc_2,
  input  logic [MC_W-1:0]   mc_3,
  input  logic [MT_W-1:0]   mt_1,
  input  logic [MT_W-1:0]   mt_2,
  input  logic [MT_W-1:0]   mt_3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FAST_W-1:0] out_msg,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_last,
  output logic [PID_W-1:0]  field_PID1,
  output logic [MC_W-1:0]   field_MC1,
  output logic [MT_W-1:0]   field_MT1,
  input  logic              cfg_load,
  input  logic [PID_W-1:0]  cfg_pid,
  input  logic [MC_W-1:0]   cfg_mc,
  input  logic [MT_W-1:0]   cfg_mt,
  output logic              len_err,
  output logic              cfg_err,
  output logic [31:0]       msg_cnt
);

  localparam logic [LEN_W-1:0] LEN_LO = LEN_W'(LEN_MIN);
  localparam logic [LEN_W-1:0] LEN_HI = LEN_W'(LEN_MAX);

  state_t state_reg, state_next;
  logic [1:0]  ptr_reg;
  logic [2:0]  mask_reg;
  logic        len_err_reg, cfg_err_reg;
  logic [31:0] msg_cnt_reg;

  logic [FAST_W-1:0] msg_reg [NUM_SLOTS];
  logic [LEN_W-1:0]  len_reg [NUM_SLOTS];
  logic [PID_W-1:0]  pid_reg [NUM_SLOTS];
  logic [MC_W-1:0]   mc_reg  [NUM_SLOTS];
  logic [MT_W-1:0]   mt_reg  [NUM_SLOTS];

  logic [FAST_W-1:0] msg_in [NUM_SLOTS];
  logic [LEN_W-1:0]  len_in [NUM_SLOTS];
  logic [PID_W-1:0]  pid_in [NUM_SLOTS];
  logic [MC_W-1:0]   mc_in  [NUM_SLOTS];
  logic [MT_W-1:0]   mt_in  [NUM_SLOTS];

  logic in_fire, capture, beat_fire, send_done, cfg_we;

  assign msg_in[0] = msg_fast_1;
  assign msg_in[1] = msg_fast_2;
  assign msg_in[2] = msg_fast_3;
  assign len_in[0] = len_1;
  assign len_in[1] = len_2;
  assign len_in[2] = len_3;
  assign pid_in[0] = pid_1;
  assign pid_in[1] = pid_2;
  assign pid_in[2] = pid_3;
  assign mc_in[0]  = mc_1;
  assign mc_in[1]  = mc_2;
  assign mc_in[2]  = mc_3;
  assign mt_in[0]  = mt_1;
  assign mt_in[1]  = mt_2;
  assign mt_in[2]  = mt_3;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // A config load owns the cycle; the triple waits so it is encoded
        // against the freshly loaded dictionary.
        in_ready = !cfg_load;
        if (in_valid && !cfg_load && (in_mask != 3'b000)) state_next = ST_SEND;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_last  = !has_higher(mask_reg, ptr_reg);
        if (out_ready && out_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  assign in_fire   = in_valid && in_ready;
  assign capture   = in_fire && (in_mask != 3'b000);
  assign beat_fire = out_valid && out_ready;
  assign send_done = beat_fire && out_last;
  assign cfg_we    = cfg_load && (state_reg == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg  <= 2'd0;
      mask_reg <= 3'b000;
    end else if (capture) begin
      mask_reg <= in_mask;
      ptr_reg  <= next_set(in_mask, 2'd0);
    end else if (beat_fire && !out_last) begin
      ptr_reg <= next_set(mask_reg, ptr_reg + 2'd1);
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        msg_reg[gi] <= '0;
        len_reg[gi] <= '0;
        pid_reg[gi] <= '0;
        mc_reg[gi]  <= '0;
        mt_reg[gi]  <= '0;
      end else if (capture) begin
        msg_reg[gi] <= msg_in[gi];
        len_reg[gi] <= len_in[gi];
        pid_reg[gi] <= pid_in[gi];
        mc_reg[gi]  <= mc_in[gi];
        mt_reg[gi]  <= mt_in[gi];
      end
    end
  end

  assign out_msg = out_valid ? msg_reg[ptr_reg] : '0;
  assign out_len = out_valid ? len_reg[ptr_reg] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_err_reg <= 1'b0;
      cfg_err_reg <= 1'b0;
      msg_cnt_reg <= 32'd0;
    end else begin
      if (beat_fire && ((out_len < LEN_LO) || (out_len > LEN_HI))) len_err_reg <= 1'b1;
      if (cfg_load && (state_reg != ST_IDLE)) cfg_err_reg <= 1'b1;
      if (beat_fire) msg_cnt_reg <= msg_cnt_reg + 32'd1;
    end
  end

  assign len_err = len_err_reg;
  assign cfg_err = cfg_err_reg;
  assign msg_cnt = msg_cnt_reg;

  stage3_fast_dict_reg #(
    .PID_W   (PID_W),
    .MC_W    (MC_W),
    .MT_W    (MT_W),
    .PID_RST (PID_RST),
    .MC_RST  (MC_RST),
    .MT_RST  (MT_RST)
  ) u_dict (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_pid   (cfg_pid),
    .cfg_mc    (cfg_mc),
    .cfg_mt    (cfg_mt),
    .upd_we    (send_done),
    .upd_pid   (pid_reg[ptr_reg]),
    .upd_mc    (mc_reg[ptr_reg]),
    .upd_mt    (mt_reg[ptr_reg]),
    .field_pid (field_PID1),
    .field_mc  (field_MC1),
    .field_mt  (field_MT1)
  );

endmodule

// File: tb/tb_stage3_fast_sched.sv
// Scoreboard bench for stage3_fast_sched: directed triples push expected beats,
// a negedge monitor pops and compares accepted beats and checks stall hold.
module tb_stage3_fast_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_mask;
  logic [63:0] msg_fast_1, msg_fast_2, msg_fast_3;
  logic [7:0]  len_1, len_2, len_3;
  logic [7:0]  pid_1, pid_2, pid_3, mc_1, mc_2, mc_3, mt_1, mt_2, mt_3;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_msg;
  logic [7:0]  out_len;
  logic [7:0]  field_PID1, field_MC1, field_MT1;
  logic        cfg_load;
  logic [7:0]  cfg_pid, cfg_mc, cfg_mt;
  logic        len_err, cfg_err;
  logic [31:0] msg_cnt;

  typedef struct {
    logic [63:0] msg;
    logic [7:0]  len;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stage3_fast_sched dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .msg_fast_1(msg_fast_1), .msg_fast_2(msg_fast_2), .msg_fast_3(msg_fast_3),
    .len_1(len_1), .len_2(len_2), .len_3(len_3),
    .pid_1(pid_1), .pid_2(pid_2), .pid_3(pid_3),
    .mc_1(mc_1), .mc_2(mc_2), .mc_3(mc_3),
    .mt_1(mt_1), .mt_2(mt_2), .mt_3(mt_3),
    .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg),
    .out_len(out_len), .out_last(out_last),
    .field_PID1(field_PID1), .field_MC1(field_MC1), .field_MT1(field_MT1),
    .cfg_load(cfg_load), .cfg_pid(cfg_pid), .cfg_mc(cfg_mc), .cfg_mt(cfg_mt),
    .len_err(len_err), .cfg_err(cfg_err), .msg_cnt(msg_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic [63:0] mk_msg(input logic [7:0] tag, input int k);
    return {48'hC0DE_0000_0000, tag, 8'(k)};
  endfunction

  // Present a triple, wait (bounded) for acceptance; expected beats go to the scoreboard.
  task automatic issue(input logic [2:0] mask, input logic [7:0] tag,
                       input logic [7:0] l1, input logic [7:0] l2, input logic [7:0] l3);
    int cyc;
    logic [7:0] lens [3];
    lens[0] = l1; lens[1] = l2; lens[2] = l3;
    in_mask = mask;
    msg_fast_1 = mk_msg(tag, 1); msg_fast_2 = mk_msg(tag, 2); msg_fast_3 = mk_msg(tag, 3);
    len_1 = l1; len_2 = l2; len_3 = l3;
    pid_1 = tag + 8'h01; pid_2 = tag + 8'h02; pid_3 = tag + 8'h03;
    mc_1  = tag + 8'h21; mc_2  = tag + 8'h22; mc_3  = tag + 8'h23;
    mt_1  = tag + 8'h41; mt_2  = tag + 8'h42; mt_3  = tag + 8'h43;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        beat_t b;
        b.msg  = mk_msg(tag, i + 1);
        b.len  = lens[i];
        b.last = ((mask >> (i + 1)) == 3'b000);
        sb.push_back(b);
      end
    end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Returns number of cycles out_valid was seen high (bounded).
  task automatic drain(output int cnt);
    cnt = 0;
    while (out_valid && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    if (out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: out_valid got 1 expected 0");
    end
  endtask

  // Monitor: compares accepted beats and hold stability during stalls.
  initial begin
    logic        stalled;
    logic [63:0] p_msg;
    logic [7:0]  p_len;
    logic        p_last;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled && out_valid) begin
          check("hold_msg", out_msg, p_msg);
          check("hold_len", 64'(out_len), 64'(p_len));
          check("hold_last", 64'(out_last), 64'(p_last));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_beat: got msg %0h expected none", out_msg);
          end else begin
            beat_t e;
            e = sb.pop_front();
            check("beat_msg", out_msg, e.msg);
            check("beat_len", 64'(out_len), 64'(e.len));
            check("beat_last", 64'(out_last), 64'(e.last));
          end
        end
        stalled = out_valid && !out_ready;
        p_msg = out_msg; p_len = out_len; p_last = out_last;
      end
    end
  end

  initial begin
    int cnt;
    rst_n = 1'b0; in_valid = 1'b0; in_mask = 3'b000; out_ready = 1'b1;
    msg_fast_1 = '0; msg_fast_2 = '0; msg_fast_3 = '0;
    len_1 = '0; len_2 = '0; len_3 = '0;
    pid_1 = '0; pid_2 = '0; pid_3 = '0; mc_1 = '0; mc_2 = '0; mc_3 = '0;
    mt_1 = '0; mt_2 = '0; mt_3 = '0;
    cfg_load = 1'b0; cfg_pid = '0; cfg_mc = '0; cfg_mt = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_msg", out_msg, 64'd0);
    check("rst_out_len", 64'(out_len), 64'd0);
    check("rst_field_pid", 64'(field_PID1), 64'd0);
    check("rst_len_err", 64'(len_err), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_msg_cnt", 64'(msg_cnt), 64'd0);

    // Full triple, out_ready high: three consecutive beats.
    issue(3'b111, 8'h10, 8'd10, 8'd11, 8'd13);
    drain(cnt);
    check("t1_valid_cycles", 64'(cnt), 64'd3);
    check("t1_in_ready", 64'(in_ready), 64'd1);
    check("t1_field_pid", 64'(field_PID1), 64'h13);
    check("t1_field_mc", 64'(field_MC1), 64'h33);
    check("t1_field_mt", 64'(field_MT1), 64'h53);
    check("t1_msg_cnt", 64'(msg_cnt), 64'd3);
    check("t1_len_err", 64'(len_err), 64'd0);

    // Sparse mask with toggling out_ready.
    out_ready = 1'b0;
    issue(3'b101, 8'h20, 8'd12, 8'd99, 8'd10);
    cnt = 0;
    while (out_valid && cnt < 40) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
      cnt++;
    end
    out_ready = 1'b1;
    check("t2_done", 64'(out_valid), 64'd0);
    check("t2_field_pid", 64'(field_PID1), 64'h23);
    check("t2_field_mc", 64'(field_MC1), 64'h43);
    check("t2_field_mt", 64'(field_MT1), 64'h63);
    check("t2_msg_cnt", 64'(msg_cnt), 64'd5);

    // Empty mask: consumed silently.
    issue(3'b000, 8'h30, 8'd11, 8'd11, 8'd11);
    for (int i = 0; i < 3; i++) begin
      check("t3_out_valid", 64'(out_valid), 64'd0);
      check("t3_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    check("t3_field_pid", 64'(field_PID1), 64'h23);
    check("t3_msg_cnt", 64'(msg_cnt), 64'd5);

    // Config load in IDLE.
    cfg_load = 1'b1; cfg_pid = 8'h5A; cfg_mc = 8'hA5; cfg_mt = 8'h3C;
    #1 check("t4_in_ready_cfg", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    check("t4_field_pid", 64'(field_PID1), 64'h5A);
    check("t4_field_mc", 64'(field_MC1), 64'hA5);
    check("t4_field_mt", 64'(field_MT1), 64'h3C);
    check("t4_cfg_err", 64'(cfg_err), 64'd0);

    // Config load during SEND is ignored.
    out_ready = 1'b0;
    issue(3'b010, 8'h40, 8'd20, 8'd11, 8'd20);
    cfg_load = 1'b1; cfg_pid = 8'hEE; cfg_mc = 8'hEE; cfg_mt = 8'hEE;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    check("t5_cfg_err", 64'(cfg_err), 64'd1);
    check("t5_field_pid_kept", 64'(field_PID1), 64'h5A);
    out_ready = 1'b1;
    drain(cnt);
    check("t5_field_pid", 64'(field_PID1), 64'h42);
    check("t5_field_mt", 64'(field_MT1), 64'h82);
    check("t5_msg_cnt", 64'(msg_cnt), 64'd6);

    // Out-of-range length is still sent and flagged.
    issue(3'b001, 8'h50, 8'd9, 8'd10, 8'd10);
    drain(cnt);
    check("t6_len_err", 64'(len_err), 64'd1);
    check("t6_msg_cnt", 64'(msg_cnt), 64'd7);
    check("t6_field_pid", 64'(field_PID1), 64'h51);

    // Reset in the middle of SEND.
    out_ready = 1'b0;
    issue(3'b111, 8'h60, 8'd10, 8'd10, 8'd10);
    rst_n = 1'b0;
    #2;
    sb.delete();
    check("t7_out_valid", 64'(out_valid), 64'd0);
    check("t7_field_pid", 64'(field_PID1), 64'd0);
    check("t7_field_mc", 64'(field_MC1), 64'd0);
    check("t7_len_err", 64'(len_err), 64'd0);
    check("t7_cfg_err", 64'(cfg_err), 64'd0);
    check("t7_msg_cnt", 64'(msg_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Traffic resumes after reset.
    issue(3'b110, 8'h70, 8'd10, 8'd13, 8'd12);
    drain(cnt);
    check("t8_valid_cycles", 64'(cnt), 64'd2);
    check("t8_field_pid", 64'(field_PID1), 64'h73);
    check("t8_field_mt", 64'(field_MT1), 64'hB3);
    check("t8_msg_cnt", 64'(msg_cnt), 64'd2);

    repeat (2) @(posedge clk);
    #1 check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
